// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_pkg
//  Description : Shared types and constants for the 4-channel TDM demux.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    // Channels per frame; slot n is carried in frame position n.
    localparam int NUM_CH    = 4;
    // Default bits per channel slot.
    localparam int W_DEFAULT = 8;
    // Width of the slot index.
    localparam int SLOT_W    = $clog2(NUM_CH);

    // Framing state: HUNT looks for a frame marker, RUN is aligned.
    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } tdm_state_e;

    // Number of beats in one complete frame.
    function automatic int frame_beats(input int w);
        return NUM_CH * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_slot_counter
//  Description : Bit-within-slot and slot-within-frame counters for the TDM
//                demux, with frame-boundary and last-beat flags.
//                W must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,       // return to slot 0, bit 0
    input  logic              load_first_i,  // current beat was slot 0 MSB
    input  logic              step_i,        // advance by one beat
    output logic [SLOT_W-1:0] slot_o,
    output logic              boundary_o,    // next beat is slot 0, bit 0
    output logic              last_bit_o,    // next beat completes a slot
    output logic              last_beat_o    // next beat completes the frame
);

    localparam int                CNT_W    = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(W - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);

    logic [CNT_W-1:0]  bit_q,  bit_d;
    logic [SLOT_W-1:0] slot_q, slot_d;

    // Next-count logic: clear beats load beats step; slot wraps mod NUM_CH.
    always_comb begin
        bit_d  = bit_q;
        slot_d = slot_q;
        if (clear_i) begin
            bit_d  = '0;
            slot_d = '0;
        end else if (load_first_i) begin
            // The marker beat already delivered bit W-1 of slot 0.
            bit_d  = CNT_W'(1);
            slot_d = '0;
        end else if (step_i) begin
            if (bit_q == BIT_LAST) begin
                bit_d  = '0;
                slot_d = slot_q + SLOT_W'(1);
            end else begin
                bit_d  = bit_q + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_q  <= '0;
            slot_q <= '0;
        end else begin
            bit_q  <= bit_d;
            slot_q <= slot_d;
        end
    end

    assign slot_o      = slot_q;
    assign boundary_o  = (slot_q == '0) && (bit_q == '0);
    assign last_bit_o  = (bit_q == BIT_LAST);
    assign last_beat_o = (bit_q == BIT_LAST) && (slot_q == SLOT_LAST);

endmodule
`default_nettype wire

// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux4
//  Description : Serial 4-slot TDM demultiplexer. Aligns to a frame marker,
//                shifts MSB-first slot words, and publishes all four channel
//                words together once a complete frame has been received.
//                W must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         data_i,
    input  logic         sync_i,
    output logic [W-1:0] ch0_o,
    output logic [W-1:0] ch1_o,
    output logic [W-1:0] ch2_o,
    output logic [W-1:0] ch3_o,
    output logic         frame_valid_o,
    output logic         sync_err_o
);

    tdm_state_e                   state_q, state_d;
    logic [W-1:0]                 shift_q, shift_d;
    logic [NUM_CH-2:0][W-1:0]     stage_q, stage_d;   // slots 0..NUM_CH-2
    logic [NUM_CH-1:0][W-1:0]     ch_q,    ch_d;
    logic                         frame_valid_q, frame_valid_d;
    logic                         sync_err_q,    sync_err_d;

    logic                         cnt_clear;
    logic                         cnt_load;
    logic                         cnt_step;
    logic [SLOT_W-1:0]            slot;
    logic                         boundary;
    logic                         last_bit;
    logic                         last_beat;

    logic [W-1:0]                 shift_next;   // shift path with this beat
    logic [W-1:0]                 shift_first;  // fresh word holding only the MSB

    assign shift_next  = {shift_q[W-2:0], data_i};
    assign shift_first = {{(W-1){1'b0}}, data_i};

    tdm_slot_counter #(
        .W            (W)
    ) u_slot_counter (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (cnt_clear),
        .load_first_i (cnt_load),
        .step_i       (cnt_step),
        .slot_o       (slot),
        .boundary_o   (boundary),
        .last_bit_o   (last_bit),
        .last_beat_o  (last_beat)
    );

    // Framing FSM, shift/staging datapath and publish logic for one beat.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        stage_d       = stage_q;
        ch_d          = ch_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        cnt_clear     = 1'b0;
        cnt_load      = 1'b0;
        cnt_step      = 1'b0;

        if (en_i) begin
            unique case (state_q)
                ST_HUNT: begin
                    // Non-marker beats are dropped while unaligned.
                    if (sync_i) begin
                        shift_d  = shift_first;
                        cnt_load = 1'b1;
                        state_d  = ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (boundary) begin
                        if (sync_i) begin
                            // Expected marker: next frame starts seamlessly.
                            shift_d  = shift_first;
                            cnt_load = 1'b1;
                        end else begin
                            // Missing marker: alignment lost.
                            sync_err_d = 1'b1;
                            shift_d    = '0;
                            cnt_clear  = 1'b1;
                            state_d    = ST_HUNT;
                        end
                    end else if (sync_i) begin
                        // Early marker: drop the partial frame and realign
                        // on this beat. Staging is fully rewritten before
                        // the next publish, so it need not be cleared.
                        sync_err_d = 1'b1;
                        shift_d    = shift_first;
                        cnt_load   = 1'b1;
                    end else begin
                        shift_d  = shift_next;
                        cnt_step = 1'b1;
                        for (int i = 0; i < NUM_CH - 1; i++) begin
                            if (last_bit && (slot == SLOT_W'(i))) begin
                                stage_d[i] = shift_next;
                            end
                        end
                        if (last_beat) begin
                            // Last slot goes straight from the shift path.
                            for (int i = 0; i < NUM_CH - 1; i++) begin
                                ch_d[i] = stage_q[i];
                            end
                            ch_d[NUM_CH-1] = shift_next;
                            frame_valid_d  = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_HUNT;
            shift_q       <= '0;
            stage_q       <= '0;
            ch_q          <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            stage_q       <= stage_d;
            ch_q          <= ch_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign ch0_o         = ch_q[0];
    assign ch1_o         = ch_q[1];
    assign ch2_o         = ch_q[2];
    assign ch3_o         = ch_q[3];
    assign frame_valid_o = frame_valid_q;
    assign sync_err_o    = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux4
//  Description : Directed self-checking bench for tdm_demux4 (W = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux4;

    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         en_i;
    logic         data_i;
    logic         sync_i;
    logic [W-1:0] ch0_o, ch1_o, ch2_o, ch3_o;
    logic         frame_valid_o;
    logic         sync_err_o;

    int checks = 0;
    int errors = 0;

    // Cycle bookkeeping, updated once per simulated clock.
    int cyc     = 0;
    int fv_cnt  = 0;
    int fv_cyc  = 0;
    int err_cnt = 0;
    int err_cyc = 0;

    tdm_demux4 #(
        .W             (W)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .data_i        (data_i),
        .sync_i        (sync_i),
        .ch0_o         (ch0_o),
        .ch1_o         (ch1_o),
        .ch2_o         (ch2_o),
        .ch3_o         (ch3_o),
        .frame_valid_o (frame_valid_o),
        .sync_err_o    (sync_err_o)
    );

    always #5 clk_i = ~clk_i;

    // One clock: drive inputs at the falling edge, observe at the next one.
    task automatic do_cycle(input logic en, input logic sy, input logic d);
        en_i   = en;
        sync_i = sy;
        data_i = d;
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
        if (frame_valid_o === 1'b1) begin
            fv_cnt++;
            fv_cyc = cyc;
        end
        if (sync_err_o === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
    endtask

    // Full frame on consecutive beats, marker on beat 0, MSB first.
    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        logic [31:0] word;
        word = {b0, b1, b2, b3};
        for (int k = 0; k < 32; k++) begin
            do_cycle(1'b1, (k == 0), word[31-k]);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        en_i   = 1'b0;
        sync_i = 1'b0;
        data_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({ch0_o, ch1_o, ch2_o, ch3_o} !== 32'h0) begin
            errors++;
            $display("FAIL reset_ch: got %h expected 00000000", {ch0_o, ch1_o, ch2_o, ch3_o});
        end
        checks++;
        if (frame_valid_o !== 1'b0 || sync_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got fv=%b err=%b expected 0 0", frame_valid_o, sync_err_o);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_single_frame();
        fv_cnt = 0; err_cnt = 0;
        // Beat with no marker while hunting must be ignored.
        do_cycle(1'b1, 1'b0, 1'b1);
        send_frame(8'hA5, 8'h3C, 8'h0F, 8'hF0);
        checks++;
        if (frame_valid_o !== 1'b1 || fv_cnt != 1) begin
            errors++;
            $display("FAIL single_fv: got fv=%b count=%0d expected 1 1", frame_valid_o, fv_cnt);
        end
        checks++;
        if ({ch0_o, ch1_o, ch2_o, ch3_o} !== 32'hA53C0FF0) begin
            errors++;
            $display("FAIL single_ch: got %h expected a53c0ff0", {ch0_o, ch1_o, ch2_o, ch3_o});
        end
        checks++;
        if (err_cnt != 0) begin
            errors++;
            $display("FAIL single_err: got %0d expected 0", err_cnt);
        end
        do_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (frame_valid_o !== 1'b0 || {ch0_o, ch1_o, ch2_o, ch3_o} !== 32'hA53C0FF0) begin
            errors++;
            $display("FAIL single_hold: got fv=%b ch=%h expected 0 a53c0ff0",
                     frame_valid_o, {ch0_o, ch1_o, ch2_o, ch3_o});
        end
    endtask

    task automatic test_back_to_back();
        int first_fv;
        logic [31:0] w2;
        fv_cnt = 0; err_cnt = 0;
        send_frame(8'h5A, 8'hC3, 8'hF0, 8'h0F);
        first_fv = fv_cyc;
        checks++;
        if ({ch0_o, ch1_o, ch2_o, ch3_o} !== 32'h5AC3F00F) begin
            errors++;
            $display("FAIL b2b_first: got %h expected 5ac3f00f", {ch0_o, ch1_o, ch2_o, ch3_o});
        end
        w2 = 32'h01020304;
        for (int k = 0; k < 32; k++) begin
            do_cycle(1'b1, (k == 0), w2[31-k]);
            if (k == 16) begin
                checks++;
                if ({ch0_o, ch1_o, ch2_o, ch3_o} !== 32'h5AC3F00F) begin
                    errors++;
                    $display("FAIL b2b_hold: got %h expected 5ac3f00f", {ch0_o, ch1_o, ch2_o, ch3_o});
                end
            end
        end
        checks++;
        if (fv_cyc - first_fv != 32 || fv_cnt != 2) begin
            errors++;
            $display("FAIL b2b_spacing: got gap=%0d pulses=%0d expected 32 2", fv_cyc - first_fv, fv_cnt);
        end
        checks++;
        if ({ch0_o, ch1_o, ch2_o, ch3_o} !== 32'h01020304 || err_cnt != 0) begin
            errors++;
            $display("FAIL b2b_second: got %h errs=%0d expected 01020304 0",
                     {ch0_o, ch1_o, ch2_o, ch3_o}, err_cnt);
        end
    endtask

    task automatic test_toggle_en();
        int   cyc0;
        logic hold_bad;
        logic [31:0] word;
        word = 32'hA53C0FF0;
        fv_cnt = 0; err_cnt = 0; hold_bad = 1'b0;
        cyc0 = cyc;
        for (int k = 0; k < 32; k++) begin
            do_cycle(1'b1, (k == 0), word[31-k]);
            if (k != 31 && {ch0_o, ch1_o, ch2_o, ch3_o} !== 32'h01020304) hold_bad = 1'b1;
            if (k == 31) begin
                // Beat 31 lands on the 63rd clock; the pulse shows in clock 64.
                checks++;
                if (frame_valid_o !== 1'b1 || cyc - cyc0 != 63) begin
                    errors++;
                    $display("FAIL toggle_fv: got fv=%b at edge %0d expected 1 at 63",
                             frame_valid_o, cyc - cyc0);
                end
            end
            // Idle cycle carries a bogus marker and inverted data.
            do_cycle(1'b0, 1'b1, ~word[31-k]);
            if (k != 31 && {ch0_o, ch1_o, ch2_o, ch3_o} !== 32'h01020304) hold_bad = 1'b1;
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL toggle_hold: got early change expected 01020304 held");
        end
        checks++;
        if ({ch0_o, ch1_o, ch2_o, ch3_o} !== 32'hA53C0FF0 || frame_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL toggle_ch: got %h fv=%b expected a53c0ff0 0",
                     {ch0_o, ch1_o, ch2_o, ch3_o}, frame_valid_o);
        end
        checks++;
        if (fv_cnt != 1 || err_cnt != 0) begin
            errors++;
            $display("FAIL toggle_counts: got fv=%0d err=%0d expected 1 0", fv_cnt, err_cnt);
        end
    endtask

    task automatic test_sync_mid_frame();
        int          c_err;
        logic [31:0] word;
        word = 32'h55667788;
        fv_cnt = 0; err_cnt = 0;
        for (int k = 0; k < 13; k++) begin
            do_cycle(1'b1, (k == 0), word[31-k]);
        end
        c_err = cyc + 1;
        send_frame(8'h11, 8'h22, 8'h33, 8'h44);
        checks++;
        if (err_cnt != 1 || err_cyc != c_err) begin
            errors++;
            $display("FAIL mid_err: got count=%0d at %0d expected 1 at %0d", err_cnt, err_cyc, c_err);
        end
        checks++;
        if (fv_cnt != 1 || fv_cyc != cyc) begin
            errors++;
            $display("FAIL mid_fv: got count=%0d at %0d expected 1 at %0d", fv_cnt, fv_cyc, cyc);
        end
        checks++;
        if ({ch0_o, ch1_o, ch2_o, ch3_o} !== 32'h11223344) begin
            errors++;
            $display("FAIL mid_ch: got %h expected 11223344", {ch0_o, ch1_o, ch2_o, ch3_o});
        end
    endtask

    task automatic test_boundary_err();
        fv_cnt = 0; err_cnt = 0;
        do_cycle(1'b1, 1'b0, 1'b1);
        checks++;
        if (sync_err_o !== 1'b1) begin
            errors++;
            $display("FAIL bnd_err: got %b expected 1", sync_err_o);
        end
        for (int k = 0; k < 10; k++) begin
            do_cycle(1'b1, 1'b0, k[0]);
        end
        checks++;
        if (err_cnt != 1 || fv_cnt != 0 || {ch0_o, ch1_o, ch2_o, ch3_o} !== 32'h11223344) begin
            errors++;
            $display("FAIL bnd_hunt: got err=%0d fv=%0d ch=%h expected 1 0 11223344",
                     err_cnt, fv_cnt, {ch0_o, ch1_o, ch2_o, ch3_o});
        end
        send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        checks++;
        if ({ch0_o, ch1_o, ch2_o, ch3_o} !== 32'hDEADBEEF || fv_cnt != 1 || err_cnt != 1) begin
            errors++;
            $display("FAIL bnd_resync: got %h fv=%0d err=%0d expected deadbeef 1 1",
                     {ch0_o, ch1_o, ch2_o, ch3_o}, fv_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] word;
        word = 32'h55667788;
        for (int k = 0; k < 20; k++) begin
            do_cycle(1'b1, (k == 0), word[31-k]);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({ch0_o, ch1_o, ch2_o, ch3_o} !== 32'h0 || frame_valid_o !== 1'b0 || sync_err_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got ch=%h fv=%b err=%b expected 0 0 0",
                     {ch0_o, ch1_o, ch2_o, ch3_o}, frame_valid_o, sync_err_o);
        end
        @(negedge clk_i);
        fv_cnt = 0; err_cnt = 0;
        do_cycle(1'b1, 1'b1, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b1);
        checks++;
        if ({ch0_o, ch1_o, ch2_o, ch3_o} !== 32'h0 || fv_cnt != 0 || err_cnt != 0) begin
            errors++;
            $display("FAIL rst_hold: got ch=%h fv=%0d err=%0d expected 0 0 0",
                     {ch0_o, ch1_o, ch2_o, ch3_o}, fv_cnt, err_cnt);
        end
        rst_ni = 1'b1;
        send_frame(8'h12, 8'h34, 8'h56, 8'h78);
        checks++;
        if ({ch0_o, ch1_o, ch2_o, ch3_o} !== 32'h12345678 || fv_cnt != 1 || err_cnt != 0) begin
            errors++;
            $display("FAIL rst_post: got %h fv=%0d err=%0d expected 12345678 1 0",
                     {ch0_o, ch1_o, ch2_o, ch3_o}, fv_cnt, err_cnt);
        end
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_toggle_en();
        test_sync_mid_frame();
        test_boundary_err();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter W, default 8: bits per channel slot.
REQ-002 Parameter NUM_CH, fixed 4: channels per frame, slot order 0..3 (slot n corresponds to select code s1s0 = n).
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assertion, active-low.
REQ-005 en_i  input  1  bit-valid strobe; only cycles with en_i=1 ("beats") carry data.
REQ-006 data_i  input  1  serial TDM data bit, sampled on beats only.
REQ-007 sync_i  input  1  frame marker, high on the beat carrying slot 0 MSB.
REQ-008 ch0_o..ch3_o  output  W each  last complete word received for each slot, held between frames.
REQ-009 frame_valid_o  output  1  one-cycle pulse: ch0_o..ch3_o updated this cycle.
REQ-010 sync_err_o  output  1  one-cycle pulse: framing violation detected.

Function
REQ-011 State machine SHALL have two states: HUNT (no frame alignment) and RUN (aligned).
REQ-012 Bit order SHALL be MSB first within a slot; a frame SHALL be exactly 4*W beats.
REQ-013 HUNT: beat with sync_i=0 discarded, no output change; beat with sync_i=1 taken as slot 0 bit W-1, slot counter=0, bit counter=1, go RUN.
REQ-014 RUN: each beat shifts data_i into the slot shift register and increments the bit counter; at bit counter W-1 the completed word is written to the staging register of the current slot, bit counter wraps to 0, slot counter increments mod 4.
REQ-015 On the beat completing slot 3, ch0_o..ch3_o SHALL all load from staging (slot 3 from the shift path) together, and frame_valid_o SHALL be 1, both visible the cycle after that beat's sampling edge (latency 1 clock).
REQ-016 Frame boundary beat (slot 0, bit 0) in RUN: sync_i=1 starts next frame, no error; sync_i=0 pulses sync_err_o, discards the beat, returns to HUNT.
REQ-017 sync_i=1 on any non-boundary beat in RUN: pulse sync_err_o, discard partial frame (staging contents not published), treat the beat as slot 0 bit W-1 of a new frame, remain RUN.
REQ-018 Cycles with en_i=0 SHALL change no state and hold all outputs; frame_valid_o and sync_err_o low.
REQ-019 sync_i and data_i SHALL be ignored when en_i=0.
REQ-020 Outputs ch*_o SHALL change only on frame_valid_o cycles; an incomplete frame never alters them.
REQ-021 Back-to-back frames with en_i=1 every cycle SHALL sustain one frame_valid_o per 4*W cycles with no dead beat.

Reset
REQ-022 rst_ni=0 SHALL immediately force state HUNT, all counters, shift and staging registers to 0, ch0_o..ch3_o=0, frame_valid_o=0, sync_err_o=0.
REQ-023 Reset mid-frame SHALL discard the partial frame; first beat after release is processed per REQ-013.

Structure
REQ-024 Shared package tdm_pkg SHALL hold the state enum (HUNT, RUN), NUM_CH, and default W.
REQ-025 One sub-module tdm_slot_counter SHALL provide bit/slot counters with wrap, boundary and last-beat flags; shift, staging and FSM stay in tdm_demux4.

Verification
REQ-026 W=8, continuous en_i, sync_i on beat 0, frame bytes 0xA5,0x3C,0x0F,0xF0 -> one cycle after beat 31 ch0..3_o=A5,3C,0F,F0, frame_valid_o one pulse.
REQ-027 Two back-to-back frames (second 01,02,03,04) -> frame_valid_o pulses exactly 32 cycles apart, outputs hold first frame values until second pulse.
REQ-028 en_i toggling 1/0 each cycle with the REQ-026 frame -> same outputs, pulse one cycle after the 32nd beat (cycle 64 relative to start), no change on idle cycles.
REQ-029 sync_i=1 at beat 13 of a frame -> sync_err_o pulse, no frame_valid_o, following 32 beats decode as a fresh frame.
REQ-030 Frame completes, boundary beat has sync_i=0 -> sync_err_o pulse, HUNT; beats ignored until next sync_i=1, outputs held.
REQ-031 rst_ni low at beat 20 then released, full frame sent -> all outputs 0 during reset, only the post-reset frame published.
